// File: rtl/handshake_rr_arbiter_if.sv
// Bus bundle for the handshake round-robin arbiter: N requester ports in, one registered port out.
// The arbiter uses the slave modport; whatever drives the requesters and sinks the output uses master.
interface handshake_rr_arbiter_if #(
    parameter int DW  = 32,
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]    m_valid;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_last;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic [IDW-1:0]  s_id;
    logic            s_last;
    logic            s_ready;

    modport slave (
        input  m_valid, m_data, m_last, s_ready,
        output m_ready, s_valid, s_data, s_id, s_last
    );

    modport master (
        output m_valid, m_data, m_last, s_ready,
        input  m_ready, s_valid, s_data, s_id, s_last
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Four-way round-robin arbiter with burst locking and a single registered output slot.
// A burst (beats up to m_last) from one requester is forwarded contiguously before re-arbitration.
module handshake_rr_arbiter #(
    parameter int DW = 32,
    parameter int N  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    handshake_rr_arbiter_if.slave bus
);
    localparam int IDW = 2;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] owner, owner_nxt;

    logic [N-1:0]   grant;
    logic           acc;
    logic           xfer;
    logic [IDW-1:0] win;
    logic [DW-1:0]  win_data;
    logic           win_last;

    logic           vld_p1;
    logic [DW-1:0]  data_p1;
    logic [IDW-1:0] id_p1;
    logic           last_p1;

    // Lowest rotation offset from base wins, so the loop runs from the far end down.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [IDW-1:0] base);
        logic [N-1:0]   g;
        logic [IDW-1:0] idx;
        g = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = base + IDW'(k);
            if (req[idx]) begin
                g      = '0;
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [IDW-1:0] onehot_idx(input logic [N-1:0] oh);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            if (oh[k]) idx = IDW'(k);
        end
        return idx;
    endfunction

    always_comb begin
        grant = '0;
        if (state == IDLE) begin
            grant = rr_pick(bus.m_valid, ptr);
        end else begin
            grant[owner] = bus.m_valid[owner];
        end
    end

    // The slot can take a beat when empty or when it is being drained this edge.
    assign acc         = !vld_p1 || bus.s_ready;
    assign bus.m_ready = acc ? grant : '0;
    assign xfer        = |bus.m_ready;
    assign win         = onehot_idx(grant);
    assign win_data    = bus.m_data[int'(win) * DW +: DW];
    assign win_last    = bus.m_last[win];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (win_last) begin
                        ptr_nxt = win + 2'd1;
                    end else begin
                        owner_nxt = win;
                        state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (win_last) begin
                        ptr_nxt   = owner + 2'd1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    // ---- stage p1: output slot ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
            last_p1 <= 1'b0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= win_data;
            id_p1   <= win;
            last_p1 <= win_last;
        end else if (vld_p1 && bus.s_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.s_valid = vld_p1;
    assign bus.s_data  = data_p1;
    assign bus.s_id    = id_p1;
    assign bus.s_last  = last_p1;
endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench for handshake_rr_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitration rules.
module tb_handshake_rr_arbiter;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    handshake_rr_arbiter_if #(.DW(32), .N(4)) bus ();

    handshake_rr_arbiter #(.DW(32), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, in plain integers.
    int          mdl_ptr;
    bit          mdl_lock;
    int          mdl_owner;
    bit          mdl_vld;
    logic [31:0] mdl_data;
    int          mdl_id;
    bit          mdl_last;

    task automatic model_reset();
        mdl_ptr   = 0;
        mdl_lock  = 0;
        mdl_owner = 0;
        mdl_vld   = 0;
        mdl_data  = '0;
        mdl_id    = 0;
        mdl_last  = 0;
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        bit         found;
        int         j;
        r     = '0;
        found = 0;
        if (mdl_vld && !bus.s_ready) return r;
        if (mdl_lock) begin
            r[mdl_owner] = bus.m_valid[mdl_owner];
        end else begin
            for (int k = 0; k < 4; k++) begin
                j = (mdl_ptr + k) % 4;
                if (!found && bus.m_valid[j]) begin
                    r[j]  = 1'b1;
                    found = 1;
                end
            end
        end
        return r;
    endfunction

    task automatic model_edge();
        logic [3:0] r;
        int         i;
        bit         lst;
        r = model_ready();
        if (r != 0) begin
            i = 0;
            for (int k = 0; k < 4; k++) if (r[k]) i = k;
            lst      = bus.m_last[i];
            mdl_vld  = 1;
            mdl_data = bus.m_data[i*32 +: 32];
            mdl_id   = i;
            mdl_last = lst;
            if (mdl_lock) begin
                if (lst) begin
                    mdl_lock = 0;
                    mdl_ptr  = (i + 1) % 4;
                end
            end else if (lst) begin
                mdl_ptr = (i + 1) % 4;
            end else begin
                mdl_lock  = 1;
                mdl_owner = i;
            end
        end else if (mdl_vld && bus.s_ready) begin
            mdl_vld = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [31:0] v);
        bus.m_data[i*32 +: 32] = v;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.s_valid, bus.s_last, bus.s_id, bus.s_data} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b l=%0b id=%0d d=%h, want all zero",
                     bus.s_valid, bus.s_last, bus.s_id, bus.s_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.m_valid = 4'b0100;
        #1;
        checks++;
        if (bus.m_ready !== 4'b0100) begin
            errors++;
            $display("FAIL reset_first_ready: got %b want 0100", bus.m_ready);
        end
        bus.m_valid = 4'b0000;
    endtask

    task automatic test_contention();
        int seq [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) set_data(i, 32'hC0DE_0000 | i);
        bus.m_valid = 4'b1111;
        bus.m_last  = 4'b1111;
        bus.s_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.m_ready !== (4'b0001 << seq[c])) begin
                errors++;
                $display("FAIL contention_ready[%0d]: got %b want %b", c, bus.m_ready, 4'b0001 << seq[c]);
            end
            tick();
            checks++;
            if (bus.s_valid !== 1'b1 || bus.s_id !== 2'(seq[c]) || bus.s_data !== (32'hC0DE_0000 | seq[c])) begin
                errors++;
                $display("FAIL contention_out[%0d]: got v=%0b id=%0d d=%h want v=1 id=%0d d=%h",
                         c, bus.s_valid, bus.s_id, bus.s_data, seq[c], 32'hC0DE_0000 | seq[c]);
            end
        end
        bus.m_valid = 4'b0000;
    endtask

    task automatic test_burst_lock();
        logic [3:0] exp_rdy [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
        int         exp_id  [5] = '{2, 2, 2, 3, 0};
        set_data(0, 32'h0000_00A0);
        set_data(3, 32'h0000_00A3);
        bus.m_valid = 4'b1101;
        bus.s_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                set_data(2, 32'hB000_0000 + c);
                bus.m_last = (c == 2) ? 4'b1101 : 4'b1001;
            end else begin
                bus.m_valid = 4'b1001;
                bus.m_last  = 4'b1111;
            end
            #1;
            checks++;
            if (bus.m_ready !== exp_rdy[c]) begin
                errors++;
                $display("FAIL burst_ready[%0d]: got %b want %b", c, bus.m_ready, exp_rdy[c]);
            end
            tick();
            checks++;
            if (bus.s_valid !== 1'b1 || bus.s_id !== 2'(exp_id[c])) begin
                errors++;
                $display("FAIL burst_id[%0d]: got v=%0b id=%0d want v=1 id=%0d", c, bus.s_valid, bus.s_id, exp_id[c]);
            end
        end
        checks++;
        if (bus.s_data !== 32'h0000_00A0) begin
            errors++;
            $display("FAIL burst_tail_data: got %h want 000000a0", bus.s_data);
        end
        bus.m_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        tick();
        bus.m_valid = 4'b0010;
        bus.m_last  = 4'b1111;
        set_data(1, 32'hA5A5_0001);
        bus.s_ready = 1'b0;
        #1;
        checks++;
        if (bus.m_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_accept_empty: got %b want 0010", bus.m_ready);
        end
        tick();
        set_data(1, 32'hA5A5_0002);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (bus.m_ready !== 4'b0000 || bus.s_valid !== 1'b1 || bus.s_data !== 32'hA5A5_0001) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got rdy=%b v=%0b d=%h want rdy=0000 v=1 d=a5a50001",
                         c, bus.m_ready, bus.s_valid, bus.s_data);
            end
            tick();
        end
        bus.s_ready = 1'b1;
        #1;
        checks++;
        if (bus.m_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 0010", bus.m_ready);
        end
        tick();
        checks++;
        if (bus.s_valid !== 1'b1 || bus.s_data !== 32'hA5A5_0002) begin
            errors++;
            $display("FAIL bp_release_out: got v=%0b d=%h want v=1 d=a5a50002", bus.s_valid, bus.s_data);
        end
    endtask

    task automatic test_drain_fill();
        bus.m_valid = 4'b0001;
        set_data(0, 32'h0000_0042);
        bus.s_ready = 1'b1;
        #1;
        checks++;
        if (bus.s_valid !== 1'b1 || bus.m_ready !== 4'b0001) begin
            errors++;
            $display("FAIL fill_pre: got v=%0b rdy=%b want v=1 rdy=0001", bus.s_valid, bus.m_ready);
        end
        tick();
        checks++;
        if (bus.s_valid !== 1'b1 || bus.s_data !== 32'h0000_0042 || bus.s_id !== 2'd0) begin
            errors++;
            $display("FAIL fill_out: got v=%0b d=%h id=%0d want v=1 d=00000042 id=0",
                     bus.s_valid, bus.s_data, bus.s_id);
        end
        bus.m_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_burst();
        tick();
        bus.m_valid = 4'b1000;
        bus.m_last  = 4'b0000;
        set_data(3, 32'hD000_0001);
        tick();
        checks++;
        if (bus.s_valid !== 1'b1 || bus.s_id !== 2'd3 || bus.s_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_beat1: got v=%0b id=%0d l=%0b want v=1 id=3 l=0", bus.s_valid, bus.s_id, bus.s_last);
        end
        set_data(3, 32'hD000_0002);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.s_valid, bus.s_last, bus.s_id, bus.s_data} !== 36'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got v=%0b l=%0b id=%0d d=%h want all zero",
                     bus.s_valid, bus.s_last, bus.s_id, bus.s_data);
        end
        for (int i = 0; i < 4; i++) set_data(i, 32'hE000_0000 | i);
        bus.m_valid = 4'b1111;
        bus.m_last  = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.m_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_first_grant: got %b want 0001", bus.m_ready);
        end
        tick();
        checks++;
        if (bus.s_id !== 2'd0 || bus.s_data !== 32'hE000_0000) begin
            errors++;
            $display("FAIL midrst_first_out: got id=%0d d=%h want id=0 d=e0000000", bus.s_id, bus.s_data);
        end
        bus.m_valid = 4'b0000;
    endtask

    task automatic test_random();
        logic [3:0] lst;
        logic [3:0] exp_r;
        for (int c = 0; c < 400; c++) begin
            bus.m_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                lst[i] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                set_data(i, $urandom);
            end
            bus.m_last  = lst;
            bus.s_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_r = model_ready();
            checks++;
            if (bus.m_ready !== exp_r) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.m_ready, exp_r);
            end
            checks++;
            if (bus.s_valid !== mdl_vld) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %0b want %0b", c, bus.s_valid, mdl_vld);
            end
            if (mdl_vld) begin
                checks++;
                if (bus.s_data !== mdl_data || bus.s_id !== 2'(mdl_id) || bus.s_last !== mdl_last) begin
                    errors++;
                    $display("FAIL rand_beat[%0d]: got d=%h id=%0d l=%0b want d=%h id=%0d l=%0b",
                             c, bus.s_data, bus.s_id, bus.s_last, mdl_data, mdl_id, mdl_last);
                end
            end
            tick();
        end
        bus.m_valid = 4'b0000;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b1;
        bus.m_valid = '0;
        bus.m_data  = '0;
        bus.m_last  = '0;
        bus.s_ready = 1'b0;
        model_reset();
        test_reset();
        test_contention();
        test_burst_lock();
        test_backpressure();
        test_drain_fill();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
